// File: rtl/queue_reader_pkg.sv
// queue_reader_pkg
// Shared types and constants for the queue_reader consumer adapter.
//   state_t      : FSM states (IDLE, STREAM, FLUSH)
//   OUT_DEPTH    : entries in the output buffer
//   COUNT_NBITS  : width of the optional delivered-word counter
package queue_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    localparam int unsigned OUT_DEPTH   = 2;
    localparam int unsigned COUNT_NBITS = 16;

endpackage

// File: rtl/queue_reader_skid_fifo2.sv
// skid_fifo2
// Two-entry register FIFO that absorbs the queue's one-cycle read latency.
// Ports:
//   clock, reset_n  : clock and asynchronous active-low reset
//   clear           : discard contents (takes priority over push/pop)
//   push, push_data : write a word (captured queue data)
//   pop             : remove the head word
//   occ             : occupancy, 0..2
//   head_data       : head word (meaningful when occ != 0)
module skid_fifo2 #(
    parameter int unsigned DATA_NBITS = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_NBITS-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            occ,
    output logic [DATA_NBITS-1:0] head_data
);

    logic [DATA_NBITS-1:0] head_q;
    logic [DATA_NBITS-1:0] tail_q;
    logic                  pop_ok;

    assign pop_ok    = pop && (occ != 2'd0);
    assign head_data = head_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            occ    <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else if (clear) begin
            occ <= '0;
        end else begin
            case ({push, pop_ok})
                2'b10: begin
                    if (occ == 2'd0) head_q <= push_data;
                    else             tail_q <= push_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    occ    <= occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; new word lands behind whatever remains.
                    if (occ == 2'd1) begin
                        head_q <= push_data;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    overflow_chk: assert property (@(posedge clock) disable iff (!reset_n)
        !(push && !clear && !pop_ok && occ == 2'd2));

endmodule

// File: rtl/queue_reader.sv
// queue_reader
// Consumer-side adapter for a Queue FIFO: issues read strobes against the
// queue's read/empty/data_out port and re-presents the words as a
// valid/ready stream, one word per clock, with a flush mode.
// Optional feature macro: QUEUE_READER_COUNT_EN adds the pop_count port.
// Ports:
//   clock, reset_n  : clock, asynchronous active-low reset
//   q_empty, q_data : queue empty flag and read data (valid cycle after q_read)
//   q_read          : queue pop strobe
//   out_valid/out_ready/out_data : downstream stream
//   flush           : discard buffered and queued words
//   flush_done      : one-cycle pulse as flush completes
//   busy            : streaming with data held, or flushing
//   pop_count       : words delivered (QUEUE_READER_COUNT_EN only)
module queue_reader
    import queue_reader_pkg::*;
#(
    parameter int unsigned DATA_NBITS = 32
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   q_empty,
    input  logic [DATA_NBITS-1:0]  q_data,
    output logic                   q_read,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_NBITS-1:0]  out_data,
    input  logic                   flush,
    output logic                   flush_done,
    output logic                   busy
`ifdef QUEUE_READER_COUNT_EN
   ,output logic [COUNT_NBITS-1:0] pop_count
`endif
);

    state_t     state;
    state_t     state_next;
    logic       inflight;
    logic [1:0] occ;
    logic       pop;
    logic       push;
    logic       clear;
    logic [2:0] demand;

    assign pop    = out_valid & out_ready;
    // Slots committed after this cycle: held words plus the one in flight,
    // less the word leaving now.
    assign demand = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign clear  = flush | (state == ST_FLUSH);
    // Data returned while flushing is dropped.
    assign push   = inflight & ~clear;

    always_comb begin
        q_read = 1'b0;
        if (reset_n && !q_empty) begin
            if (state == ST_FLUSH) q_read = 1'b1;
            else                   q_read = (demand < 3'(OUT_DEPTH));
        end
    end

    assign out_valid = (occ != 2'd0) && (state != ST_FLUSH);
    assign busy      = ((state == ST_STREAM) && ((occ != 2'd0) || inflight))
                     || (state == ST_FLUSH);

    always_comb begin
        state_next = state;
        flush_done = 1'b0;
        if (flush) begin
            state_next = ST_FLUSH;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!q_empty) state_next = ST_STREAM;
                end
                ST_STREAM: begin
                    if (occ == 2'd0 && !inflight && q_empty) state_next = ST_IDLE;
                end
                ST_FLUSH: begin
                    if (q_empty && !inflight && occ == 2'd0) begin
                        state_next = ST_IDLE;
                        flush_done = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            inflight <= 1'b0;
        end else begin
            state    <= state_next;
            inflight <= q_read;
        end
    end

    skid_fifo2 #(
        .DATA_NBITS (DATA_NBITS)
    ) u_buf (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (clear),
        .push      (push),
        .push_data (q_data),
        .pop       (pop),
        .occ       (occ),
        .head_data (out_data)
    );

`ifdef QUEUE_READER_COUNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)  pop_count <= '0;
        else if (pop)  pop_count <= pop_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_queue_reader.sv
`timescale 1ns/100ps
module tb_queue_reader;
    import queue_reader_pkg::*;

    localparam int unsigned W = 32;

    logic         clock     = 1'b0;
    logic         reset_n   = 1'b1;
    logic         q_empty   = 1'b1;
    logic         out_ready = 1'b0;
    logic         flush     = 1'b0;
    logic [W-1:0] q_data    = '0;
    logic         q_read;
    logic         out_valid;
    logic         flush_done;
    logic         busy;
    logic [W-1:0] out_data;
`ifdef QUEUE_READER_COUNT_EN
    logic [COUNT_NBITS-1:0] pop_count;
    logic [COUNT_NBITS-1:0] exp_count = '0;
`endif

    logic [W-1:0] qmem[$];    // contents of the attached queue
    logic [W-1:0] exp_q[$];   // scoreboard: words expected downstream, in order
    int unsigned  pop_log[$]; // cycle numbers of observed handshakes
    int unsigned  checks    = 0;
    int unsigned  failures  = 0;
    int unsigned  cyc       = 0;
    int unsigned  qread_cnt = 0;
    int unsigned  fd_cnt    = 0;
    logic         prev_hold = 1'b0;
    logic [W-1:0] prev_data = '0;

    queue_reader #(
        .DATA_NBITS (W)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .q_empty    (q_empty),
        .q_data     (q_data),
        .q_read     (q_read),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .flush      (flush),
        .flush_done (flush_done),
        .busy       (busy)
`ifdef QUEUE_READER_COUNT_EN
       ,.pop_count  (pop_count)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    // Queue model: one-cycle read latency.
    always @(posedge clock) begin
        if (reset_n && q_read && qmem.size() != 0) begin
            q_data <= qmem.pop_front();
            qread_cnt++;
        end
    end

    initial forever begin
        @(posedge clock);
        #2;
        q_empty = (qmem.size() == 0);
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard consumer.
    always @(negedge clock) begin
        if (reset_n) begin
            check("qread_while_empty", {31'd0, q_read & q_empty}, '0);
            if (flush_done) fd_cnt++;
            if (prev_hold) begin
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_data", out_data, prev_data);
            end
`ifdef QUEUE_READER_COUNT_EN
            check("pop_count", {16'd0, pop_count}, {16'd0, exp_count});
`endif
            if (out_valid && out_ready) begin
                pop_log.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word actual=%0h expected=none", out_data);
                end else begin
                    check("word", out_data, exp_q.pop_front());
                end
`ifdef QUEUE_READER_COUNT_EN
                exp_count = exp_count + 1'b1;
`endif
            end
            prev_hold = out_valid && !out_ready && !flush;
            prev_data = out_data;
        end else begin
            prev_hold = 1'b0;
`ifdef QUEUE_READER_COUNT_EN
            exp_count = '0;
`endif
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_word(input logic [W-1:0] w);
        qmem.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic wait_empty(input string name, input int unsigned bound);
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            step();
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic do_flush();
        int unsigned fd0 = fd_cnt;
        int unsigned n   = 0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        exp_q.delete();
        check("flush_valid_drop", {31'd0, out_valid}, '0);
        while (fd_cnt == fd0 && n < 200) begin
            step();
            n++;
        end
        step();
        check("flush_done_once", fd_cnt - fd0, 32'd1);
        check("flush_drained", qmem.size(), 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_q_read"}, {31'd0, q_read}, '0);
        check({tag, "_out_valid"}, {31'd0, out_valid}, '0);
        check({tag, "_out_data"}, out_data, '0);
        check({tag, "_flush_done"}, {31'd0, flush_done}, '0);
        check({tag, "_busy"}, {31'd0, busy}, '0);
`ifdef QUEUE_READER_COUNT_EN
        check({tag, "_pop_count"}, {16'd0, pop_count}, '0);
`endif
    endtask

    initial begin
        int unsigned t0;
        int unsigned n0;

        // Power-on reset.
        #1 reset_n = 1'b0;
        @(negedge clock);
        check_zero_outputs("reset");
        step();
        reset_n = 1'b1;
        step();

        // Streaming: 16 words, latency and one-per-cycle throughput.
        pop_log.delete();
        t0 = cyc;
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) push_word(W'(i));
        @(negedge clock);
        check("latency_q_read", {31'd0, q_read}, 32'd1);
        step();
        wait_empty("stream_drain", 100);
        check("stream_count", pop_log.size(), 16);
        if (pop_log.size() == 16) begin
            check("stream_first_cycle", pop_log[0], t0 + 2);
            check("stream_last_cycle", pop_log[15], t0 + 17);
        end
`ifdef QUEUE_READER_COUNT_EN
        check("stream_pop_count", {16'd0, pop_count}, 32'd16);
`endif

        // Backpressure: only two reads while stalled.
        out_ready = 1'b0;
        step();
        n0 = qread_cnt;
        for (int i = 1; i <= 5; i++) push_word(W'(i));
        repeat (8) step();
        check("bp_reads", qread_cnt - n0, 32'd2);
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        check("bp_data", out_data, 32'd1);
        check("bp_busy", {31'd0, busy}, 32'd1);
        out_ready = 1'b1;
        wait_empty("bp_drain", 100);

        // Empty boundary: single words separated by empty gaps.
        for (int i = 0; i < 12; i++) begin
            push_word($urandom);
            repeat (1 + $urandom_range(0, 2)) step();
        end
        wait_empty("boundary_drain", 100);

        // Flush with buffer full and queue still holding words.
        out_ready = 1'b0;
        step();
        for (int i = 1; i <= 8; i++) push_word(W'(32'h100 + i));
        repeat (6) step();
        check("flush_pre_valid", {31'd0, out_valid}, 32'd1);
        do_flush();
        check("flush_busy", {31'd0, busy}, '0);
        check("flush_idle", {30'd0, dut.state}, {30'd0, ST_IDLE});
        out_ready = 1'b1;
        push_word(32'hA5A5_0001);
        wait_empty("post_flush_drain", 50);

        // Reset mid-operation: the in-flight word is lost, queued words remain.
        out_ready = 1'b0;
        step();
        for (int i = 1; i <= 3; i++) push_word(W'(32'h200 + i));
        step();
        step();
        reset_n = 1'b0;
        @(negedge clock);
        check_zero_outputs("midreset");
        step();
        check("midreset_q_read", {31'd0, q_read}, '0);
        reset_n = 1'b1;
        exp_q = qmem;
        check("midreset_left", qmem.size(), 1);
        out_ready = 1'b1;
        step();
        wait_empty("midreset_drain", 50);

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 1500; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) begin
                do_flush();
            end else begin
                if ($urandom_range(0, 2) == 0) push_word($urandom);
                step();
            end
        end
        out_ready = 1'b1;
        wait_empty("random_drain", 300);

`ifdef QUEUE_READER_COUNT_EN
        // Counter wrap: 65537 deliveries from zero.
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 65537; i++) push_word(W'(i));
        wait_empty("wrap_drain", 66000);
        out_ready = 1'b0;
        step();
        check("wrap_pop_count", {16'd0, pop_count}, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
